// File: rtl/data_sram_responder_pkg.sv
// ---------------------------------------------------------------------------
// data_sram_responder_pkg
//   Shared constants for the data-SRAM responder:
//     - byte-lane count of the write-enable bus
//     - default address-high value that selects the MMIO block
//     - MMIO register offsets (byte offsets within the MMIO window)
//     - byte_merge(): applies per-lane write enables to a 32-bit word
// ---------------------------------------------------------------------------
package data_sram_responder_pkg;

   localparam int          WEN_W            = 4;
   localparam logic [15:0] MMIO_BASE_HI_DEF = 16'hBFAF;

   localparam logic [15:0] OFF_LED        = 16'h0000;
   localparam logic [15:0] OFF_SWITCH     = 16'h0004;
   localparam logic [15:0] OFF_NUM        = 16'h0008;
   localparam logic [15:0] OFF_TIMER      = 16'h000C;
   localparam logic [15:0] OFF_TIMER_CMP  = 16'h0010;
   localparam logic [15:0] OFF_TIMER_STAT = 16'h0014;

   // Lane i of the result comes from new_val when wen[i] is set,
   // otherwise from old_val.
   function automatic logic [31:0] byte_merge(input logic [31:0]      old_val,
                                              input logic [31:0]      new_val,
                                              input logic [WEN_W-1:0] wen);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < WEN_W; i++) begin
         if (wen[i]) begin
            res[8*i +: 8] = new_val[8*i +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/data_sram_responder_ram.sv
// ---------------------------------------------------------------------------
// sram_bytewe_ram
//   Single-port 32-bit RAM with four byte-lane write enables, synchronous
//   read (1-cycle latency), write-first. Written as a plain array so the
//   tools map it to block RAM; the read register has no reset for the same
//   reason (the parent handles reset of the visible read data).
//
//   Ports:
//     clk    in   clock
//     en     in   access enable (read or write)
//     wen    in   byte write enables, 0 = read
//     addr   in   word address, AW bits
//     wdata  in   write data
//     rdata  out  read data, updated on the edge after an enabled access
// ---------------------------------------------------------------------------
module sram_bytewe_ram
   import data_sram_responder_pkg::*;
#(
   parameter int AW = 12
) (
   input  logic             clk,
   input  logic             en,
   input  logic [WEN_W-1:0] wen,
   input  logic [AW-1:0]    addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < WEN_W; i++) begin
            if (wen[i]) begin
               mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
         // Write-first: the read port shows the merged word being written.
         rdata <= byte_merge(mem[addr], wdata, wen);
      end
   end

endmodule

// File: rtl/data_sram_responder.sv
// ---------------------------------------------------------------------------
// data_sram_responder
//   Responder end of the core's data-SRAM interface. Requests are decoded
//   either to an internal byte-writable RAM or to a small MMIO block
//   (LED, switches, seven-segment value, free-running timer with compare
//   interrupt). Reads return data one cycle after the request; writes
//   complete at the request edge with no response.
//
//   Ports:
//     clk              in   system clock, rising edge
//     rst              in   asynchronous active-low reset
//     data_sram_en     in   access request
//     data_sram_wen    in   byte write enables (0 = read)
//     data_sram_addr   in   byte address, bits [1:0] ignored
//     data_sram_wdata  in   write data
//     data_sram_rdata  out  read data, valid the cycle after a read
//     switch           in   board switches (asynchronous)
//     led              out  LED register
//     num_data         out  seven-segment display value
//     timer_int        out  timer interrupt (level, = pending bit)
// ---------------------------------------------------------------------------
module data_sram_responder
   import data_sram_responder_pkg::*;
#(
   parameter int          RAM_AW       = 12,
   parameter logic [15:0] MMIO_BASE_HI = MMIO_BASE_HI_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             data_sram_en,
   input  logic [WEN_W-1:0] data_sram_wen,
   input  logic [31:0]      data_sram_addr,
   input  logic [31:0]      data_sram_wdata,
   output logic [31:0]      data_sram_rdata,
   input  logic [7:0]       switch,
   output logic [15:0]      led,
   output logic [31:0]      num_data,
   output logic             timer_int
);

   // ------------------------------------------------------------------
   // Request decode
   // ------------------------------------------------------------------
   logic        mmio_sel;
   logic [15:0] mmio_off;
   logic        is_read;
   logic        mmio_wr;
   logic        ram_en;
   logic [1:0]  unused_addr_lsb;

   assign mmio_sel        = (data_sram_addr[31:16] == MMIO_BASE_HI);
   assign mmio_off        = {data_sram_addr[15:2], 2'b00};
   assign is_read         = data_sram_en && (data_sram_wen == '0);
   assign mmio_wr         = data_sram_en && (data_sram_wen != '0) && mmio_sel;
   assign unused_addr_lsb = data_sram_addr[1:0];

   // The RAM has no reset of its own; gating with rst keeps a clock edge
   // during reset from landing a write.
   assign ram_en = data_sram_en && !mmio_sel && rst;

   // ------------------------------------------------------------------
   // RAM
   // ------------------------------------------------------------------
   logic [31:0] ram_q;

   sram_bytewe_ram #(
      .AW    (RAM_AW)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .wen   (data_sram_wen),
      .addr  (data_sram_addr[RAM_AW+1:2]),
      .wdata (data_sram_wdata),
      .rdata (ram_q)
   );

   // ------------------------------------------------------------------
   // MMIO state
   // ------------------------------------------------------------------
   logic [15:0] led_reg,       led_next;
   logic [31:0] num_reg,       num_next;
   logic [31:0] timer_reg,     timer_next;
   logic [31:0] cmp_reg,       cmp_next;
   logic        pending_reg,   pending_next;
   logic [7:0]  sw_meta_reg;
   logic [7:0]  sw_sync_reg;

   logic        pend_set;
   logic        pend_clr;

   always_comb begin
      led_next     = led_reg;
      num_next     = num_reg;
      timer_next   = timer_reg + 32'd1;
      cmp_next     = cmp_reg;
      pend_set     = (timer_reg == cmp_reg) && (cmp_reg != 32'd0);
      pend_clr     = 1'b0;

      if (mmio_wr) begin
         case (mmio_off)
            OFF_LED: begin
               // Only the two low lanes exist in the LED register.
               for (int i = 0; i < 2; i++) begin
                  if (data_sram_wen[i]) begin
                     led_next[8*i +: 8] = data_sram_wdata[8*i +: 8];
                  end
               end
            end
            OFF_NUM:       num_next   = byte_merge(num_reg, data_sram_wdata, data_sram_wen);
            // A software write replaces the increment for this cycle;
            // unwritten lanes keep their current (un-incremented) value.
            OFF_TIMER:     timer_next = byte_merge(timer_reg, data_sram_wdata, data_sram_wen);
            OFF_TIMER_CMP: cmp_next   = byte_merge(cmp_reg, data_sram_wdata, data_sram_wen);
            OFF_TIMER_STAT: pend_clr  = data_sram_wen[0] && data_sram_wdata[0];
            default: ;
         endcase
      end

      // A coincident match wins over a software clear.
      pending_next = pend_set || (pending_reg && !pend_clr);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led_reg     <= '0;
         num_reg     <= '0;
         timer_reg   <= '0;
         cmp_reg     <= '0;
         pending_reg <= 1'b0;
         sw_meta_reg <= '0;
         sw_sync_reg <= '0;
      end else begin
         led_reg     <= led_next;
         num_reg     <= num_next;
         timer_reg   <= timer_next;
         cmp_reg     <= cmp_next;
         pending_reg <= pending_next;
         sw_meta_reg <= switch;
         sw_sync_reg <= sw_meta_reg;
      end
   end

   assign led       = led_reg;
   assign num_data  = num_reg;
   assign timer_int = pending_reg;

   // ------------------------------------------------------------------
   // MMIO read value, taken from the registers as they stand at the
   // request edge (before that edge's update).
   // ------------------------------------------------------------------
   logic [31:0] mmio_rd;

   always_comb begin
      mmio_rd = '0;
      case (mmio_off)
         OFF_LED:        mmio_rd = {16'h0000, led_reg};
         OFF_SWITCH:     mmio_rd = {24'h000000, sw_sync_reg};
         OFF_NUM:        mmio_rd = num_reg;
         OFF_TIMER:      mmio_rd = timer_reg;
         OFF_TIMER_CMP:  mmio_rd = cmp_reg;
         OFF_TIMER_STAT: mmio_rd = {31'd0, pending_reg};
         default:        mmio_rd = '0;
      endcase
   end

   // ------------------------------------------------------------------
   // Read response. rd_valid_reg marks the cycle after a read; in that
   // cycle the registered select picks RAM or the captured MMIO word.
   // In every other cycle the last returned word is held in hold_reg, so
   // the visible read data behaves as a register that reset clears.
   // ------------------------------------------------------------------
   logic        rd_valid_reg;
   logic        rd_mmio_reg;
   logic [31:0] mmio_q_reg;
   logic [31:0] hold_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_valid_reg <= 1'b0;
         rd_mmio_reg  <= 1'b0;
         mmio_q_reg   <= '0;
         hold_reg     <= '0;
      end else begin
         rd_valid_reg <= is_read;
         hold_reg     <= data_sram_rdata;
         if (is_read) begin
            rd_mmio_reg <= mmio_sel;
            mmio_q_reg  <= mmio_rd;
         end
      end
   end

   always_comb begin
      data_sram_rdata = hold_reg;
      if (rd_valid_reg) begin
         data_sram_rdata = rd_mmio_reg ? mmio_q_reg : ram_q;
      end
   end

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;

   logic        clk;
   logic        rst;
   logic        en;
   logic [3:0]  wen;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [7:0]  sw;
   logic [15:0] led;
   logic [31:0] num_data;
   logic        timer_int;

   int n_checks;
   int n_fail;

   data_sram_responder dut (
      .clk             (clk),
      .rst             (rst),
      .data_sram_en    (en),
      .data_sram_wen   (wen),
      .data_sram_addr  (addr),
      .data_sram_wdata (wdata),
      .data_sram_rdata (rdata),
      .switch          (sw),
      .led             (led),
      .num_data        (num_data),
      .timer_int       (timer_int)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
      en = 1'b1; wen = w; addr = a; wdata = d;
      tick();
      en = 1'b0; wen = 4'h0;
      $display("write addr=%h wen=%b data=%h", a, w, d);
   endtask

   task automatic do_read(input logic [31:0] a);
      en = 1'b1; wen = 4'h0; addr = a;
      tick();
      en = 1'b0;
      $display("read  addr=%h -> rdata=%h", a, rdata);
   endtask

   task automatic test_reset();
      rst = 1'b0; en = 1'b0; wen = 4'h0; addr = '0; wdata = '0; sw = 8'h00;
      tick(); tick();
      n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected %h", rdata, 32'h0); end
      n_checks++; if (led !== 16'h0) begin n_fail++; $display("FAIL reset_led: got %h expected %h", led, 16'h0); end
      n_checks++; if (num_data !== 32'h0) begin n_fail++; $display("FAIL reset_num: got %h expected %h", num_data, 32'h0); end
      n_checks++; if (timer_int !== 1'b0) begin n_fail++; $display("FAIL reset_timer_int: got %b expected 0", timer_int); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_ram_rw();
      do_write(32'h0000_0100, 4'hF, 32'hDEADBEEF);
      do_read(32'h0000_0100);
      n_checks++; if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ram_full_word: got %h expected %h", rdata, 32'hDEADBEEF); end
      do_write(32'h0000_0100, 4'b0010, 32'h0000AA00);
      do_read(32'h0000_0100);
      n_checks++; if (rdata !== 32'hDEADAAEF) begin n_fail++; $display("FAIL ram_byte_merge: got %h expected %h", rdata, 32'hDEADAAEF); end
      tick();
      n_checks++; if (rdata !== 32'hDEADAAEF) begin n_fail++; $display("FAIL ram_hold_idle: got %h expected %h", rdata, 32'hDEADAAEF); end
      // en=0 with a write pattern on the bus must not touch memory.
      en = 1'b0; wen = 4'hF; addr = 32'h0000_0100; wdata = 32'h0;
      tick();
      wen = 4'h0;
      // Upper address bits alias onto the same word.
      do_read(32'h0000_4100);
      n_checks++; if (rdata !== 32'hDEADAAEF) begin n_fail++; $display("FAIL ram_en0_alias: got %h expected %h", rdata, 32'hDEADAAEF); end
   endtask

   task automatic test_back_to_back();
      do_write(32'h0000_0104, 4'hF, 32'h11111111);
      do_write(32'h0000_0108, 4'hF, 32'h22222222);
      en = 1'b1; wen = 4'h0; addr = 32'h0000_0104;
      tick();
      addr = 32'h0000_0108;
      n_checks++; if (rdata !== 32'h11111111) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", rdata, 32'h11111111); end
      tick();
      en = 1'b0;
      n_checks++; if (rdata !== 32'h22222222) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", rdata, 32'h22222222); end
      $display("back-to-back reads 0104/0108 done");
      do_write(32'h0000_010C, 4'hF, 32'h33333333);
      do_read(32'h0000_010C);
      n_checks++; if (rdata !== 32'h33333333) begin n_fail++; $display("FAIL read_after_write: got %h expected %h", rdata, 32'h33333333); end
   endtask

   task automatic test_mmio();
      do_write(32'hBFAF_0000, 4'hF, 32'h00001234);
      do_write(32'hBFAF_0008, 4'hF, 32'h89ABCDEF);
      n_checks++; if (led !== 16'h1234) begin n_fail++; $display("FAIL led_write: got %h expected %h", led, 16'h1234); end
      n_checks++; if (num_data !== 32'h89ABCDEF) begin n_fail++; $display("FAIL num_write: got %h expected %h", num_data, 32'h89ABCDEF); end
      do_write(32'hBFAF_0000, 4'b0010, 32'hFFFF5600);
      do_read(32'hBFAF_0000);
      n_checks++; if (rdata !== 32'h00005634) begin n_fail++; $display("FAIL led_byte_read: got %h expected %h", rdata, 32'h00005634); end
      sw = 8'h5A;
      tick(); tick(); tick();
      do_read(32'hBFAF_0004);
      n_checks++; if (rdata !== 32'h0000005A) begin n_fail++; $display("FAIL switch_read: got %h expected %h", rdata, 32'h0000005A); end
      do_write(32'hBFAF_0020, 4'hF, 32'hFFFFFFFF);
      do_read(32'hBFAF_0020);
      n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h expected %h", rdata, 32'h0); end
      do_read(32'hBFAF_0008);
      n_checks++; if (rdata !== 32'h89ABCDEF) begin n_fail++; $display("FAIL num_read: got %h expected %h", rdata, 32'h89ABCDEF); end
   endtask

   task automatic test_timer_irq();
      do_write(32'hBFAF_000C, 4'hF, 32'd0);
      do_write(32'hBFAF_0010, 4'hF, 32'd20);
      // Tick n sees pre-increment TIMER == n; the match at 20 sets pending.
      for (int n = 1; n <= 25; n++) begin
         tick();
         n_checks++;
         if (timer_int !== (n >= 20)) begin
            n_fail++; $display("FAIL timer_irq_tick%0d: got %b expected %b", n, timer_int, (n >= 20));
         end
      end
      $display("timer compare at 20: timer_int=%b", timer_int);
      do_write(32'hBFAF_0014, 4'h1, 32'h1);
      n_checks++; if (timer_int !== 1'b0) begin n_fail++; $display("FAIL timer_clear: got %b expected 0", timer_int); end
      tick(); tick(); tick();
      n_checks++; if (timer_int !== 1'b0) begin n_fail++; $display("FAIL timer_stays_clear: got %b expected 0", timer_int); end
      // Clear lands on the same edge as a match: the set must win.
      do_write(32'hBFAF_0010, 4'hF, 32'd40);
      do_write(32'hBFAF_000C, 4'hF, 32'd38);
      tick(); tick();
      do_write(32'hBFAF_0014, 4'h1, 32'h1);
      n_checks++; if (timer_int !== 1'b1) begin n_fail++; $display("FAIL set_beats_clear: got %b expected 1", timer_int); end
      do_write(32'hBFAF_0014, 4'h1, 32'h1);
      n_checks++; if (timer_int !== 1'b0) begin n_fail++; $display("FAIL clear_after_set: got %b expected 0", timer_int); end
   endtask

   task automatic test_cmp_zero();
      int seen;
      seen = 0;
      do_write(32'hBFAF_0010, 4'hF, 32'd0);
      do_write(32'hBFAF_000C, 4'hF, 32'd0);
      for (int n = 0; n < 256; n++) begin
         tick();
         n_checks++;
         if (timer_int !== 1'b0) begin
            n_fail++; seen++;
            if (seen < 4) $display("FAIL cmp_zero_tick%0d: got %b expected 0", n, timer_int);
         end
      end
      $display("cmp=0 run of 256 cycles done");
   endtask

   task automatic test_wrap();
      do_write(32'hBFAF_000C, 4'hF, 32'hFFFFFFFE);
      tick();
      en = 1'b1; wen = 4'h0; addr = 32'hBFAF_000C;
      tick();
      n_checks++; if (rdata !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL wrap_first: got %h expected %h", rdata, 32'hFFFFFFFF); end
      tick();
      en = 1'b0;
      n_checks++; if (rdata !== 32'h00000000) begin n_fail++; $display("FAIL wrap_second: got %h expected %h", rdata, 32'h0); end
      $display("timer wrap reads done");
   endtask

   task automatic test_reset_mid();
      do_write(32'hBFAF_0010, 4'hF, 32'd8);
      do_write(32'hBFAF_000C, 4'hF, 32'd5);
      tick(); tick(); tick(); tick(); tick();
      n_checks++; if (timer_int !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq: got %b expected 1", timer_int); end
      do_write(32'h0000_0200, 4'hF, 32'hCAFEF00D);
      en = 1'b1; wen = 4'h0; addr = 32'h0000_0200;
      tick();
      n_checks++; if (rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL pre_reset_read: got %h expected %h", rdata, 32'hCAFEF00D); end
      addr = 32'h0000_0104;
      #2 rst = 1'b0;
      #1;
      n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL mid_reset_rdata: got %h expected 0", rdata); end
      n_checks++; if (led !== 16'h0) begin n_fail++; $display("FAIL mid_reset_led: got %h expected 0", led); end
      n_checks++; if (num_data !== 32'h0) begin n_fail++; $display("FAIL mid_reset_num: got %h expected 0", num_data); end
      n_checks++; if (timer_int !== 1'b0) begin n_fail++; $display("FAIL mid_reset_irq: got %b expected 0", timer_int); end
      // A write presented across an edge while in reset must not land.
      en = 1'b1; wen = 4'hF; addr = 32'h0000_0200; wdata = 32'h0;
      tick();
      en = 1'b0; wen = 4'h0;
      #2 rst = 1'b1;
      #1;
      n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL post_release_rdata: got %h expected 0", rdata); end
      en = 1'b1; addr = 32'hBFAF_000C;
      tick();
      n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL post_reset_timer0: got %h expected 0", rdata); end
      tick();
      en = 1'b0;
      n_checks++; if (rdata !== 32'd1) begin n_fail++; $display("FAIL post_reset_timer1: got %h expected 1", rdata); end
      do_read(32'h0000_0200);
      n_checks++; if (rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL ram_survives_reset: got %h expected %h", rdata, 32'hCAFEF00D); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_ram_rw();
      test_back_to_back();
      test_mmio();
      test_timer_irq();
      test_cmp_zero();
      test_wrap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
